// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and FSM encoding for the fetch front-end
package fetch_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam int          PC_STEP      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO of {pc, instr} pairs
// Ports: clock/reset (async, active-high); push/push_pc/push_instr write side;
// pop read side; flush empties the queue and wins over push; full/empty/count
// status; head_pc/head_instr show the head entry, or the last popped entry
// (reset: pc 0, NOP) while empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [XLEN-1:0]            push_pc,
    input  logic [31:0]                push_instr,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [XLEN-1:0]            head_pc,
    output logic [31:0]                head_instr
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [XLEN-1:0] last_pc;
    logic [31:0]     last_instr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            last_pc    <= '0;
            last_instr <= NOP_INSTR;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                last_pc    <= pc_mem[rd_ptr];
                last_instr <= instr_mem[rd_ptr];
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    assign head_pc    = empty ? last_pc    : pc_mem[rd_ptr];
    assign head_instr = empty ? last_instr : instr_mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front-end with PC, imem port and prefetch queue
// Ports: clock/reset (async, active-high); imem_req/imem_addr request pulse and
// address; imem_valid/imem_rdata response; redirect/redirect_pc flush and restart;
// out_valid/out_ready/out_instr/out_pc decode handshake.
// FETCH_PERF_CNT_EN: adds fetch_count (pushes) and flush_count (redirects).
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     flush_count
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] fetch_pc, pc_next, pc_inc, addr_next;
    logic            req_next;
    logic            push, pop, flush;
    logic            full, empty;
    logic [CW-1:0]   count;
    logic            room_after_push;

    assign pc_inc          = fetch_pc + XLEN'(PC_STEP);
    assign pop             = out_valid && out_ready;
    assign out_valid       = !empty;
    // Back-to-back issue only when the entry being pushed leaves a free slot.
    assign room_after_push = (int'(count) + 1 - (pop ? 1 : 0)) < QDEPTH;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            state     <= state_next;
            fetch_pc  <= pc_next;
            imem_req  <= req_next;
            imem_addr <= addr_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = fetch_pc;
        req_next   = 1'b0;
        addr_next  = imem_addr;
        push       = 1'b0;
        flush      = 1'b0;
        if (redirect) begin
            flush   = 1'b1;
            pc_next = redirect_pc & ~XLEN'(3);
            // A response arriving with the redirect is dropped here, so only
            // a still-outstanding request needs the DRAIN detour.
            if (state != IDLE && !imem_valid) begin
                state_next = DRAIN;
            end else begin
                state_next = IDLE;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (!full) begin
                        req_next   = 1'b1;
                        addr_next  = fetch_pc;
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_valid) begin
                        push    = 1'b1;
                        pc_next = pc_inc;
                        if (room_after_push) begin
                            req_next   = 1'b1;
                            addr_next  = pc_inc;
                            state_next = WAIT;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_valid) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_pc    (fetch_pc),
        .push_instr (imem_rdata),
        .pop        (pop),
        .flush      (flush),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .head_pc    (out_pc),
        .head_instr (out_instr)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (push) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redirect) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mem_lat = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_data = '0;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .flush_count (flush_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [15:0] idx;
        idx = a[17:2] + 16'd1;
        return {16'hAAAA, idx};
    endfunction

    // Instruction memory: a request seen after edge N answers during the
    // cycle that starts at edge N+mem_lat.
    always begin
        @(posedge clock);
        #1;
        imem_valid = 1'b0;
        if (reset) begin
            pend_cnt = 0;
        end else begin
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = pend_data;
                end
            end
            if (imem_req) begin
                pend_cnt  = mem_lat;
                pend_data = mem_word(imem_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && !imem_req; i++) tick();
        check({tag, "_req_timeout"}, imem_req, 1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check({tag, "_valid_timeout"}, out_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq;
        int seen;

        // Reset values, then release at t=50 with 1-cycle memory
        #20;
        check("rst_req",   imem_req,  0);
        check("rst_addr",  imem_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_instr", out_instr, 32'h0000_0013);
        check("rst_pc",    out_pc,    0);
        #30 reset = 1'b0;

        tick();
        check("t1_req0",   imem_req,  1);
        check("t1_addr0",  imem_addr, 0);
        check("t1_v_e0",   out_valid, 0);
        tick();
        check("t1_v_e1",   out_valid, 0);
        check("t1_req_e1", imem_req,  0);
        tick();
        check("t1_v_e2",   out_valid, 1);
        check("t1_pc0",    out_pc,    0);
        check("t1_ins0",   out_instr, 32'hAAAA_0001);
        check("t1_req1",   imem_req,  1);
        check("t1_addr1",  imem_addr, 32'h4);
        tick();
        check("t1_v_e3",   out_valid, 0);
        tick();
        check("t1_v_e4",   out_valid, 1);
        check("t1_pc1",    out_pc,    32'h4);
        check("t1_ins1",   out_instr, 32'hAAAA_0002);

        // Backpressure: queue fills with two entries and fetch stops
        out_ready = 1'b0;
        do_reset();
        nreq = 0;
        repeat (12) begin
            tick();
            if (imem_req) nreq++;
        end
        check("t2_nreq",   nreq,      2);
        check("t2_valid",  out_valid, 1);
        check("t2_pc",     out_pc,    0);
        check("t2_ins",    out_instr, 32'hAAAA_0001);
        out_ready = 1'b1;
        tick();
        check("t2_pc_pop", out_pc,    32'h4);
        wait_req("t2");
        check("t2_resume", imem_addr, 32'h8);

        // Redirect in WAIT, stale response arrives later and is dropped
        mem_lat   = 3;
        out_ready = 1'b1;
        do_reset();
        tick();
        check("t3_req0",   imem_req,  1);
        check("t3_addr0",  imem_addr, 0);
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        pend_data   = 32'hDEAD_0000;
        mem_lat     = 1;
        tick();
        redirect = 1'b0;
        check("t3_v_flush", out_valid, 0);
        check("t3_req_rd",  imem_req,  0);
        wait_req("t3");
        check("t3_addr",   imem_addr, 32'h100);
        wait_valid("t3");
        check("t3_pc",     out_pc,    32'h100);
        check("t3_ins",    out_instr, 32'hAAAA_0041);

        // Redirect coincident with a response and a pop
        out_ready = 1'b0;
        do_reset();
        repeat (4) tick();
        check("t4_ivalid", imem_valid, 1);
        check("t4_qvalid", out_valid,  1);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        out_ready   = 1'b1;
        tick();
        redirect = 1'b0;
        check("t4_v_flush", out_valid, 0);
        check("t4_req_rd",  imem_req,  0);
        tick();
        check("t4_req",    imem_req,  1);
        check("t4_addr",   imem_addr, 32'h200);
        wait_valid("t4");
        check("t4_pc",     out_pc,    32'h200);
        check("t4_ins",    out_instr, 32'hAAAA_0081);

        // PC wrap at the top of the address space, misaligned redirect
        out_ready = 1'b1;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        check("t5_noreq",  imem_req,  0);
        tick();
        check("t5_req",    imem_req,  1);
        check("t5_addr",   imem_addr, 32'hFFFF_FFFC);
        wait_valid("t5");
        check("t5_pc",     out_pc,    32'hFFFF_FFFC);
        check("t5_ins",    out_instr, mem_word(32'hFFFF_FFFC));
        wait_req("t5_wrap");
        check("t5_wrap",   imem_addr, 32'h0);

`ifdef FETCH_PERF_CNT_EN
        // Counters: five pushes, two redirects, then async reset mid-cycle
        out_ready = 1'b1;
        mem_lat   = 1;
        do_reset();
        seen = 0;
        for (int i = 0; i < 40 && seen < 5; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("pc_seen",   seen,        5);
        check("pc_fetch5", fetch_count, 5);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        tick();
        redirect = 1'b0;
        check("pc_fetch",  fetch_count, 5);
        check("pc_flush",  flush_count, 2);
        #3 reset = 1'b1;
        #1;
        check("pc_rst_fetch", fetch_count, 0);
        check("pc_rst_flush", flush_count, 0);
        reset = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
